// File: rtl/tx_slot_gate_pkg.sv
// Shared definitions for the optical slot gate: tuser length field, FSM states,
// and the packet-length to beat-count conversion.
package tx_slot_gate_pkg;

    localparam int LEN_LO = 0;
    localparam int LEN_HI = 15;
    localparam int LEN_W  = LEN_HI - LEN_LO + 1;

    typedef enum logic {
        ST_WAIT_SOP = 1'b0,
        ST_PASS     = 1'b1
    } state_t;

    // One extra bit so a maximal length cannot wrap; a zero-length packet still
    // occupies one beat on the bus.
    function automatic logic [LEN_W:0] beats_from_len(input logic [LEN_W-1:0] len,
                                                      input int unsigned data_width);
        int unsigned bpb;
        int unsigned n;
        bpb = data_width / 8;
        n   = (32'(len) + bpb - 1) / bpb;
        if (n == 0)
            n = 1;
        return (LEN_W + 1)'(n);
    endfunction

endpackage

// File: rtl/tx_slot_gate_timer.sv
// Free-running slot timer: slot position, slot numbering, guard window and
// remaining-cycle count for the current optical circuit slot.
module tx_slot_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] slot_cycles,
    input  logic [W-1:0] guard_cycles,
    output logic         slot_start,
    output logic [7:0]   slot_index,
    output logic         cfg_err,
    output logic         open,
    output logic [W:0]   remain
);

    logic [W-1:0] r_cnt;
    logic [7:0]   r_slot_index;
    logic         r_slot_start;
    logic         w_cfg_err;
    logic         w_wrap;
    logic [W-1:0] w_cnt_nxt;

    assign w_cfg_err = (slot_cycles == '0) || (guard_cycles >= slot_cycles);
    // Compare with >= so a slot shrunk below the current count wraps right away.
    assign w_wrap    = !w_cfg_err && (r_cnt >= slot_cycles - W'(1));
    assign w_cnt_nxt = (w_cfg_err || w_wrap) ? '0 : r_cnt + W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_slot_index <= '0;
            r_slot_start <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_slot_start <= !w_cfg_err && (w_cnt_nxt == '0);
            if (w_wrap)
                r_slot_index <= r_slot_index + 8'd1;
        end
    end

    assign slot_start = r_slot_start;
    assign slot_index = r_slot_index;
    assign cfg_err    = w_cfg_err;
    assign open       = !w_cfg_err && (r_cnt >= guard_cycles);
    // Clamp covers the single cycle after slot_cycles is shrunk below the count.
    assign remain     = (r_cnt >= slot_cycles) ? '0
                                               : {1'b0, slot_cycles} - {1'b0, r_cnt};

endmodule

// File: rtl/tx_slot_gate.sv
// Releases a packet only when it fits in the open part of the current optical
// slot; decision is taken at SOP, the rest of the packet streams through.
module tx_slot_gate
    import tx_slot_gate_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SLOT_CNT_WIDTH       = 16
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    input  logic                              gate_en,
    input  logic [SLOT_CNT_WIDTH-1:0]         slot_cycles,
    input  logic [SLOT_CNT_WIDTH-1:0]         guard_cycles,
    output logic                              slot_start,
    output logic [7:0]                        slot_index,
    output logic                              cfg_err,
    output logic [31:0]                       pkt_sent_cnt,
    output logic [31:0]                       pkt_defer_cnt,
    output logic [31:0]                       overrun_cnt
);

    state_t                  r_state, w_state_nxt;
    logic                    r_run;
    logic                    r_held;
    logic [31:0]             r_sent, r_defer, r_overrun;
    logic                    w_open;
    logic [SLOT_CNT_WIDTH:0] w_remain;
    logic [LEN_W:0]          w_beats;
    logic                    w_allow;
    logic                    w_xfer;
    logic                    w_sop_xfer;
    logic                    w_hold;

    tx_slot_timer #(.W(SLOT_CNT_WIDTH)) u_timer (
        .clk          (axi_aclk),
        .rst_n        (axi_aresetn),
        .slot_cycles  (slot_cycles),
        .guard_cycles (guard_cycles),
        .slot_start   (slot_start),
        .slot_index   (slot_index),
        .cfg_err      (cfg_err),
        .open         (w_open),
        .remain       (w_remain)
    );

    assign w_beats = beats_from_len(s_axis_tuser[LEN_HI:LEN_LO], C_S_AXIS_DATA_WIDTH);
    assign w_allow = !gate_en || (w_open && (32'(w_remain) >= 32'(w_beats)));

    always_comb begin
        w_state_nxt   = r_state;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        w_hold        = 1'b0;
        // r_run keeps the handshake quiet until the first clock after reset.
        if (r_run) begin
            case (r_state)
                ST_WAIT_SOP: begin
                    m_axis_tvalid = s_axis_tvalid && w_allow;
                    s_axis_tready = m_axis_tready && w_allow;
                    w_hold        = s_axis_tvalid && !w_allow;
                    if (s_axis_tvalid && s_axis_tready && !s_axis_tlast)
                        w_state_nxt = ST_PASS;
                end
                ST_PASS: begin
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tready = m_axis_tready;
                    if (s_axis_tvalid && s_axis_tready && s_axis_tlast)
                        w_state_nxt = ST_WAIT_SOP;
                end
                default: w_state_nxt = ST_WAIT_SOP;
            endcase
        end
    end

    assign w_xfer     = s_axis_tvalid && s_axis_tready;
    assign w_sop_xfer = w_xfer && (r_state == ST_WAIT_SOP);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state   <= ST_WAIT_SOP;
            r_run     <= 1'b0;
            r_held    <= 1'b0;
            r_sent    <= '0;
            r_defer   <= '0;
            r_overrun <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_sop_xfer)
                r_held <= 1'b0;
            else if (w_hold)
                r_held <= 1'b1;
            if (w_sop_xfer && r_sent != '1)
                r_sent <= r_sent + 32'd1;
            if (w_hold && !r_held && r_defer != '1)
                r_defer <= r_defer + 32'd1;
            if (w_xfer && s_axis_tlast && !w_open && r_overrun != '1)
                r_overrun <= r_overrun + 32'd1;
        end
    end

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;
    assign pkt_sent_cnt  = r_sent;
    assign pkt_defer_cnt = r_defer;
    assign overrun_cnt   = r_overrun;

endmodule

// File: tb/tb_tx_slot_gate.sv
// Directed bench for tx_slot_gate: slot gating, wrap/guard holding, overrun,
// configuration error and mid-packet reset, with hand-computed expectations.
module tb_tx_slot_gate;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] s_tdata;
    logic [31:0]  s_tstrb;
    logic [127:0] s_tuser;
    logic         s_tvalid, s_tlast, s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic [127:0] m_tuser;
    logic         m_tvalid, m_tlast, m_tready;
    logic         gate_en;
    logic [15:0]  slot_cycles, guard_cycles;
    logic         slot_start, cfg_err;
    logic [7:0]   slot_index;
    logic [31:0]  sent, defer, overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    tx_slot_gate dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .gate_en       (gate_en),
        .slot_cycles   (slot_cycles),
        .guard_cycles  (guard_cycles),
        .slot_start    (slot_start),
        .slot_index    (slot_index),
        .cfg_err       (cfg_err),
        .pkt_sent_cnt  (sent),
        .pkt_defer_cnt (defer),
        .overrun_cnt   (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, want %0h (cyc %0d)", tag, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int target);
        while (cyc < target)
            step();
    endtask

    task automatic beat(input logic [15:0] len, input logic last, input logic [7:0] tag);
        s_tvalid = 1'b1;
        s_tlast  = last;
        s_tuser  = {64'hA5A5_0000_0000_5A5A, 48'h0, len};
        s_tdata  = {32{tag}};
        s_tstrb  = '1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Release lands 1 time unit after a rising edge; that cycle is slot count 0.
    task automatic do_reset(input logic [15:0] slot, input logic [15:0] guard, input logic gate);
        rst_n        = 1'b0;
        idle();
        m_tready     = 1'b1;
        slot_cycles  = slot;
        guard_cycles = guard;
        gate_en      = gate;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        logic seen_ss, seen_mv;
        s_tdata = '0; s_tstrb = '0; s_tuser = '0;

        // Reset state
        do_reset(16'd100, 16'd10, 1'b0);
        @(negedge clk);
        chk("rst_sent",   64'(sent), 64'd0);
        chk("rst_slotix", 64'(slot_index), 64'd0);
        chk("rst_ss",     64'(slot_start), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);

        // 1: transparent mode, 1-beat packet in the guard forwarded same cycle
        goto(3);
        beat(16'd20, 1'b1, 8'h3C);
        @(negedge clk);
        chk("t1_mvalid", 64'(m_tvalid), 64'd1);
        chk("t1_sready", 64'(s_tready), 64'd1);
        chk("t1_tdata",  m_tdata[255:192], {8{8'h3C}});
        chk("t1_tuser",  m_tuser[127:64], 64'hA5A5_0000_0000_5A5A);
        chk("t1_tlast",  64'(m_tlast), 64'd1);
        step(); idle();
        chk("t1_sent",    64'(sent), 64'd1);
        chk("t1_defer",   64'(defer), 64'd0);
        chk("t1_overrun", 64'(overrun), 64'd1);

        // 2: 4-beat packet held through the guard, released at count 10
        do_reset(16'd100, 16'd10, 1'b1);
        goto(3);
        beat(16'd100, 1'b0, 8'h01);
        @(negedge clk);
        chk("t2_hold3", 64'(m_tvalid), 64'd0);
        chk("t2_srdy3", 64'(s_tready), 64'd0);
        goto(9);
        @(negedge clk);
        chk("t2_hold9", 64'(m_tvalid), 64'd0);
        goto(10);
        @(negedge clk);
        chk("t2_rel10", 64'(m_tvalid), 64'd1);
        step(); beat(16'd100, 1'b0, 8'h02);
        chk("t2_sent",  64'(sent), 64'd1);
        chk("t2_defer", 64'(defer), 64'd1);
        step(); beat(16'd100, 1'b0, 8'h03);
        step(); beat(16'd100, 1'b1, 8'h04);
        step(); idle();
        chk("t2_defer_end", 64'(defer), 64'd1);
        chk("t2_overrun",   64'(overrun), 64'd0);

        // 3: 8 beats with 7 remaining -> held across wrap and guard
        do_reset(16'd100, 16'd10, 1'b1);
        goto(93);
        beat(16'd256, 1'b0, 8'h11);
        @(negedge clk);
        chk("t3_hold93", 64'(m_tvalid), 64'd0);
        goto(99);
        @(negedge clk);
        chk("t3_hold99", 64'(m_tvalid), 64'd0);
        chk("t3_ss99",   64'(slot_start), 64'd0);
        goto(100);
        @(negedge clk);
        chk("t3_ss0",    64'(slot_start), 64'd1);
        chk("t3_slotix", 64'(slot_index), 64'd1);
        chk("t3_hold0",  64'(m_tvalid), 64'd0);
        goto(109);
        @(negedge clk);
        chk("t3_hold9", 64'(m_tvalid), 64'd0);
        goto(110);
        @(negedge clk);
        chk("t3_rel10", 64'(m_tvalid), 64'd1);
        for (int i = 1; i < 8; i++) begin
            step(); beat(16'd256, i == 7, 8'(8'h11 + i));
        end
        step(); idle();
        chk("t3_sent",    64'(sent), 64'd1);
        chk("t3_defer",   64'(defer), 64'd1);
        chk("t3_overrun", 64'(overrun), 64'd0);
        // Exact fit: 4 beats with 4 remaining are released at once
        goto(196);
        beat(16'd128, 1'b0, 8'h21);
        @(negedge clk);
        chk("t3_fit", 64'(m_tvalid), 64'd1);
        for (int i = 1; i < 4; i++) begin
            step(); beat(16'd128, i == 3, 8'(8'h21 + i));
        end
        step(); idle();
        chk("t3_fit_sent", 64'(sent), 64'd2);
        // Maximal length never fits a 100-cycle slot
        goto(210);
        beat(16'hFFFF, 1'b1, 8'h2F);
        @(negedge clk);
        chk("t3_maxlen", 64'(m_tvalid), 64'd0);
        step(); idle();
        chk("t3_maxdefer", 64'(defer), 64'd2);

        // 4: backpressure stretches a packet past the slot end -> overrun
        do_reset(16'd100, 16'd10, 1'b1);
        goto(95);
        beat(16'd160, 1'b0, 8'h41);
        @(negedge clk);
        chk("t4_sop", 64'(m_tvalid), 64'd1);
        step(); beat(16'd160, 1'b0, 8'h42);
        step(); beat(16'd160, 1'b0, 8'h43); m_tready = 1'b0;
        goto(101);
        @(negedge clk);
        chk("t4_stall_srdy", 64'(s_tready), 64'd0);
        chk("t4_pass_mvld",  64'(m_tvalid), 64'd1);
        goto(107);
        m_tready = 1'b1;
        step(); beat(16'd160, 1'b0, 8'h44);
        step(); beat(16'd160, 1'b1, 8'h45);
        step(); idle();
        chk("t4_sent",    64'(sent), 64'd1);
        chk("t4_defer",   64'(defer), 64'd0);
        chk("t4_overrun", 64'(overrun), 64'd1);

        // 5: guard == slot is a configuration error; nothing flows
        do_reset(16'd100, 16'd100, 1'b1);
        @(negedge clk);
        chk("t5_cfgerr", 64'(cfg_err), 64'd1);
        goto(20);
        beat(16'd20, 1'b1, 8'h51);
        seen_ss = 1'b0;
        seen_mv = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            seen_ss |= slot_start;
            seen_mv |= m_tvalid;
            step();
        end
        chk("t5_no_ss",   64'(seen_ss), 64'd0);
        chk("t5_no_mv",   64'(seen_mv), 64'd0);
        chk("t5_slotix",  64'(slot_index), 64'd0);
        guard_cycles = 16'd10;
        @(negedge clk);
        chk("t5_cfg_ok", 64'(cfg_err), 64'd0);
        goto(179);
        @(negedge clk);
        chk("t5_hold9", 64'(m_tvalid), 64'd0);
        goto(180);
        @(negedge clk);
        chk("t5_rel10", 64'(m_tvalid), 64'd1);
        step(); idle();
        chk("t5_sent",  64'(sent), 64'd1);
        chk("t5_defer", 64'(defer), 64'd1);

        // 6: reset while on beat 2 of a 6-beat packet
        do_reset(16'd100, 16'd10, 1'b0);
        goto(20);
        beat(16'd192, 1'b0, 8'h61);
        step(); beat(16'd192, 1'b0, 8'h62);
        step(); beat(16'd192, 1'b0, 8'h63);
        @(negedge clk);
        chk("t6_pass", 64'(m_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_mvld", 64'(m_tvalid), 64'd0);
        chk("t6_rst_srdy", 64'(s_tready), 64'd0);
        @(posedge clk);
        #1;
        chk("t6_rst_sent",   64'(sent), 64'd0);
        chk("t6_rst_slotix", 64'(slot_index), 64'd0);
        do_reset(16'd100, 16'd10, 1'b1);
        goto(3);
        beat(16'd100, 1'b0, 8'h71);
        @(negedge clk);
        chk("t6_hold3", 64'(m_tvalid), 64'd0);
        goto(10);
        @(negedge clk);
        chk("t6_rel10", 64'(m_tvalid), 64'd1);
        for (int i = 1; i < 4; i++) begin
            step(); beat(16'd100, i == 3, 8'(8'h71 + i));
        end
        step(); idle();
        chk("t6_sent",  64'(sent), 64'd1);
        chk("t6_defer", 64'(defer), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
